rggen_backdoor_arbiter: RTL

Shares one register access port between the bus-side frontdoor requester and the simulation backdoor requester. It grants one requester at a time and captures that request into registers. It drives the captured request to the register/field access port and returns the completion handshake and read data to the granted requester. Backdoor requests win by default; a bounded-streak rule guarantees frontdoor progress.

---
 rtl/rggen_backdoor_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rggen_backdoor_arbiter.sv
// Arbiter sharing one register access port between a frontdoor (bus) requester and a
// simulation backdoor requester. Backdoor wins by default; a streak limit bounds starvation.
module rggen_backdoor_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_frontdoor_valid,
    input  logic [DATA_WIDTH-1:0] i_frontdoor_read_mask,
    input  logic [DATA_WIDTH-1:0] i_frontdoor_write_mask,
    input  logic [DATA_WIDTH-1:0] i_frontdoor_write_data,
    output logic                  o_frontdoor_ready,
    output logic [DATA_WIDTH-1:0] o_frontdoor_read_data,
    input  logic                  i_backdoor_valid,
    input  logic [DATA_WIDTH-1:0] i_backdoor_read_mask,
    input  logic [DATA_WIDTH-1:0] i_backdoor_write_mask,
    input  logic [DATA_WIDTH-1:0] i_backdoor_write_data,
    output logic                  o_backdoor_ready,
    output logic [DATA_WIDTH-1:0] o_backdoor_read_data,
    output logic                  o_pending_valid,
    output logic                  o_access_valid,
    output logic [DATA_WIDTH-1:0] o_access_read_mask,
    output logic [DATA_WIDTH-1:0] o_access_write_mask,
    output logic [DATA_WIDTH-1:0] o_access_write_data,
    input  logic                  i_access_ready,
    input  logic [DATA_WIDTH-1:0] i_access_read_data
);

    typedef enum logic [1:0] {
        StIdle,
        StFront,
        StBack
    } state_e;

    localparam logic [3:0] StreakLimit = 4'(MAX_STREAK);

    state_e                state_q;
    state_e                state_d;
    logic [3:0]            streak_q;
    logic [3:0]            streak_d;
    logic                  pending_q;
    logic                  pending_d;
    logic [DATA_WIDTH-1:0] read_mask_q;
    logic [DATA_WIDTH-1:0] read_mask_d;
    logic [DATA_WIDTH-1:0] write_mask_q;
    logic [DATA_WIDTH-1:0] write_mask_d;
    logic [DATA_WIDTH-1:0] write_data_q;
    logic [DATA_WIDTH-1:0] write_data_d;

    logic streak_full;
    logic grant_front;
    logic grant_back;
    logic front_done;
    logic back_done;

    // Backdoor wins ties unless the frontdoor has already waited out a full streak.
    always_comb begin
        streak_full = (streak_q >= StreakLimit);
        grant_front = (state_q == StIdle) && i_frontdoor_valid &&
                      (!i_backdoor_valid || streak_full);
        grant_back  = (state_q == StIdle) && i_backdoor_valid &&
                      (!i_frontdoor_valid || !streak_full);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_back) begin
                    state_d = StBack;
                end else if (grant_front) begin
                    state_d = StFront;
                end
            end
            StFront, StBack: begin
                if (i_access_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        streak_d = streak_q;
        if (grant_front) begin
            streak_d = '0;
        end else if (grant_back) begin
            if (i_frontdoor_valid) begin
                streak_d = streak_full ? StreakLimit : streak_q + 4'd1;
            end else begin
                streak_d = '0;
            end
        end
    end

    // Clear beats set so a grant always retires the pending indication.
    always_comb begin
        pending_d = pending_q;
        if ((state_q == StFront) && i_backdoor_valid) begin
            pending_d = 1'b1;
        end
        if (grant_back) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        read_mask_d  = read_mask_q;
        write_mask_d = write_mask_q;
        write_data_d = write_data_q;
        if (grant_back) begin
            read_mask_d  = i_backdoor_read_mask;
            write_mask_d = i_backdoor_write_mask;
            write_data_d = i_backdoor_write_data;
        end else if (grant_front) begin
            read_mask_d  = i_frontdoor_read_mask;
            write_mask_d = i_frontdoor_write_mask;
            write_data_d = i_frontdoor_write_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            streak_q     <= '0;
            pending_q    <= 1'b0;
            read_mask_q  <= '0;
            write_mask_q <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            pending_q    <= pending_d;
            read_mask_q  <= read_mask_d;
            write_mask_q <= write_mask_d;
            write_data_q <= write_data_d;
        end
    end

    // Completion is suppressed while reset is asserted so an abandoned access never signals.
    always_comb begin
        front_done = i_rst_n && (state_q == StFront) && i_access_ready;
        back_done  = i_rst_n && (state_q == StBack) && i_access_ready;
    end

    always_comb begin
        o_access_valid        = (state_q != StIdle);
        o_access_read_mask    = read_mask_q;
        o_access_write_mask   = write_mask_q;
        o_access_write_data   = write_data_q;
        o_pending_valid       = pending_q;
        o_frontdoor_ready     = front_done;
        o_backdoor_ready      = back_done;
        o_frontdoor_read_data = front_done ? i_access_read_data : '0;
        o_backdoor_read_data  = back_done ? i_access_read_data : '0;
    end

endmodule
